register_dump: RTL and testbench
================================

REGISTER_DUMP -- requirements
Module: register_dump

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data width of the register block being read.
REQ-002 The block SHALL have parameter DEPTH, default 16, number of registers; power of two, at least 2; AW = $clog2(DEPTH).
REQ-003 Port clk  in  1  single clock; all logic on rising edge.
REQ-004 Port reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 Port start  in  1  single-cycle request to begin a dump; honoured only in IDLE.
REQ-006 Port first_addr  in  AW  first register address, sampled on the accepted start.
REQ-007 Port last_addr  in  AW  last register address, sampled on the accepted start.
REQ-008 Port busy  out  1  high from the cycle after an accepted start until done.
REQ-009 Port done  out  1  one-cycle pulse after the last word is accepted downstream.
REQ-010 Port r_en  out  1  read enable to register block.
REQ-011 Port r_addr  out  AW  read address to register block.
REQ-012 Port r_value  in  WIDTH  read data, valid exactly one cycle after r_en was sampled high.
REQ-013 Port out_valid  out  1  stream word valid.
REQ-014 Port out_ready  in  1  downstream accept; a transfer occurs when out_valid and out_ready are both high.
REQ-015 Port out_data  out  WIDTH  register contents.
REQ-016 Port out_addr  out  AW  address the word was read from.
REQ-017 Port out_last  out  1  high with the final word of a dump.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-019 IDLE->RUN SHALL occur on start; the block SHALL latch first_addr and count = ((last_addr - first_addr) mod DEPTH) + 1.
REQ-020 The address SHALL increment modulo DEPTH; last_addr < first_addr SHALL wrap through DEPTH-1 to 0, and last_addr == first_addr SHALL dump exactly one word.
REQ-021 In RUN, r_en SHALL be asserted only when the output buffer has a free slot after counting the read in flight.
REQ-022 Each issued read SHALL be captured, with its address, into a 2-entry FIFO output buffer one cycle after issue.
REQ-023 With out_ready held high, the block SHALL issue one read per cycle, and the first out_valid SHALL appear 2 cycles after start.
REQ-024 RUN->DRAIN SHALL occur when the count-th read is issued; DRAIN->IDLE SHALL occur on the transfer carrying out_last, with done pulsed in that next cycle.
REQ-025 Stream words SHALL leave in address order with no loss or duplication under any out_ready pattern.
REQ-026 out_data, out_addr and out_last SHALL remain stable while out_valid is high and out_ready is low.
REQ-027 start SHALL be ignored while busy, with no effect on the dump in progress.
REQ-028 r_en SHALL be low in IDLE and DRAIN.
REQ-029 The block SHALL keep issuing reads when out_ready rises in the same cycle the buffer is full, provided a slot frees that cycle.

Reset
REQ-030 Assertion of reset_n low SHALL immediately force IDLE and clear busy, done, r_en, out_valid and out_last, and empty the buffer.
REQ-031 Reset SHALL force r_addr, out_data and out_addr to 0.
REQ-032 Reset mid-dump SHALL abandon the dump without a done pulse.
REQ-033 After reset_n deasserts, the block SHALL accept start on the first rising edge.

Structure
REQ-034 The package register_dump_pkg SHALL hold the FSM state typedef and the constant READ_LATENCY = 1.
REQ-035 The 2-entry output buffer SHALL be the sub-module dump_skid_buffer, parameterised by WIDTH+AW+1.

Verification
REQ-036 Full dump: preload regs[i] = 16'hA000+i, first=0, last=15, out_ready=1 -> 16 words 0xA000..0xA00F in order, out_last on addr 15, done pulses once.
REQ-037 Wrap: first=14, last=1 -> addresses 14,15,0,1 in order, out_last on addr 1.
REQ-038 Single word: first=last=7 -> exactly one word, addr 7, out_last=1.
REQ-039 Backpressure: out_ready random at 30% -> same 16-word sequence as REQ-036, r_en never issued with the buffer full, data stable while stalled.
REQ-040 start while busy, plus reset_n low after the 5th word -> no extra dump; outputs cleared immediately, no done, and a new start succeeds.

Source files
------------

// File: rtl/register_dump_pkg.sv
// Shared types and constants for the register dump engine.
package register_dump_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam int READ_LATENCY = 1;
   localparam int BUF_DEPTH    = 2;

   // Words owed to the output buffer next cycle: stored, plus the one returning, minus the one leaving.
   function automatic logic [2:0] pending_words(input logic [1:0] occ,
                                                input logic       inflight,
                                                input logic       pop);
      return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
   endfunction

endpackage

// File: rtl/register_dump_skid_buffer.sv
// Two-entry FIFO holding read words until the downstream stream accepts them.
module dump_skid_buffer #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic [1:0]    count
);

   logic [DW-1:0] ent0_q, ent0_d;
   logic [DW-1:0] ent1_q, ent1_d;
   logic [1:0]    count_q, count_d;
   logic          pop_s;

   assign pop_s     = (count_q != 2'd0) & pop_ready;
   assign out_valid = (count_q != 2'd0);
   assign out_data  = ent0_q;
   assign count     = count_q;

   // Head entry only changes on a pop or a push into an empty buffer, so a stalled word stays put.
   always_comb begin
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      count_d = count_q;
      case ({push, pop_s})
         2'b10: begin
            if (count_q == 2'd0) begin
               ent0_d  = push_data;
               count_d = 2'd1;
            end else if (count_q == 2'd1) begin
               ent1_d  = push_data;
               count_d = 2'd2;
            end else begin
               count_d = count_q;
            end
         end
         2'b01: begin
            ent0_d  = ent1_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd2) begin
               ent0_d = ent1_q;
               ent1_d = push_data;
            end else begin
               ent0_d = push_data;
            end
         end
         default: begin
            count_d = count_q;
         end
      endcase
   end

   // Storage and occupancy registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ent0_q  <= {DW{1'b0}};
         ent1_q  <= {DW{1'b0}};
         count_q <= 2'd0;
      end else begin
         ent0_q  <= ent0_d;
         ent1_q  <= ent1_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/register_dump.sv
// Walks a register address range, reads each register and streams {data, addr, last} downstream.
module register_dump
   import register_dump_pkg::*;
#(
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [AW-1:0]    first_addr,
   input  logic [AW-1:0]    last_addr,
   output logic             busy,
   output logic             done,
   output logic             r_en,
   output logic [AW-1:0]    r_addr,
   input  logic [WIDTH-1:0] r_value,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [AW-1:0]    out_addr,
   output logic             out_last
);

   localparam int DW = WIDTH + AW + 1;

   state_e          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [AW:0]     remain_q, remain_d;
   logic            inflight_q, inflight_d;
   logic [AW-1:0]   inflight_addr_q, inflight_addr_d;
   logic            inflight_last_q, inflight_last_d;
   logic            done_q, done_d;

   logic [1:0]      buf_count_s;
   logic            buf_valid_s;
   logic [DW-1:0]   buf_data_s;
   logic            buf_last_s;
   logic            pop_s;
   logic [2:0]      pending_s;
   logic [AW-1:0]   span_s;
   logic            r_en_s;

   assign pop_s     = buf_valid_s & out_ready;
   assign span_s    = last_addr - first_addr;
   assign pending_s = pending_words(buf_count_s, inflight_q, pop_s);

   // A read may issue only if its word is guaranteed a slot when it returns.
   always_comb begin
      r_en_s = 1'b0;
      if ((state_q == ST_RUN) && (remain_q != {(AW+1){1'b0}}) &&
          (pending_s <= 3'(BUF_DEPTH - READ_LATENCY))) begin
         r_en_s = 1'b1;
      end else begin
         r_en_s = 1'b0;
      end
   end

   // Next-state logic for the dump sequencer.
   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      remain_d        = remain_q;
      done_d          = 1'b0;
      inflight_d      = r_en_s;
      inflight_addr_d = addr_q;
      inflight_last_d = (remain_q == (AW+1)'(1'b1));
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_RUN;
               addr_d   = first_addr;
               remain_d = {1'b0, span_s} + (AW+1)'(1'b1);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (r_en_s) begin
               addr_d   = addr_q + AW'(1'b1);
               remain_d = remain_q - (AW+1)'(1'b1);
               if (remain_q == (AW+1)'(1'b1)) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (pop_s && buf_last_s) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sequencer and read-tracking registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= ST_IDLE;
         addr_q          <= {AW{1'b0}};
         remain_q        <= {(AW+1){1'b0}};
         inflight_q      <= 1'b0;
         inflight_addr_q <= {AW{1'b0}};
         inflight_last_q <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         remain_q        <= remain_d;
         inflight_q      <= inflight_d;
         inflight_addr_q <= inflight_addr_d;
         inflight_last_q <= inflight_last_d;
         done_q          <= done_d;
      end
   end

   dump_skid_buffer #(
      .DW (DW)
   ) u_buf (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (inflight_q),
      .push_data ({inflight_last_q, inflight_addr_q, r_value}),
      .pop_ready (out_ready),
      .out_valid (buf_valid_s),
      .out_data  (buf_data_s),
      .count     (buf_count_s)
   );

   assign {buf_last_s, out_addr, out_data} = buf_data_s;
   assign out_valid = buf_valid_s;
   assign out_last  = buf_last_s & buf_valid_s;
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign r_en      = r_en_s;
   assign r_addr    = addr_q;

endmodule

// File: tb/tb_register_dump.sv
// Directed bench for register_dump: full, wrapped, single-word, backpressured and reset-interrupted dumps.
module tb_register_dump;

   localparam int WIDTH = 16;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             start;
   logic [AW-1:0]    first_addr;
   logic [AW-1:0]    last_addr;
   logic             busy;
   logic             done;
   logic             r_en;
   logic [AW-1:0]    r_addr;
   logic [WIDTH-1:0] r_value;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [AW-1:0]    out_addr;
   logic             out_last;

   logic [WIDTH-1:0] regs [DEPTH];

   int total = 0;
   int bad   = 0;
   int issued;
   int xferred;
   int done_cnt = 0;
   logic stall_prev;
   logic [WIDTH+AW:0] snap;

   logic [AW-1:0]    got_addr[$];
   logic [WIDTH-1:0] got_data[$];
   logic             got_last[$];

   register_dump #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .first_addr (first_addr),
      .last_addr  (last_addr),
      .busy       (busy),
      .done       (done),
      .r_en       (r_en),
      .r_addr     (r_addr),
      .r_value    (r_value),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_addr   (out_addr),
      .out_last   (out_last)
   );

   always #5 clk = ~clk;

   // Register block model: data one cycle after r_en is sampled.
   always @(posedge clk) begin
      if (r_en) r_value <= regs[r_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Stream monitor: records transfers, checks stall stability and buffer headroom for every read.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            issued     = 0;
            xferred    = 0;
            stall_prev = 1'b0;
         end else begin
            if (stall_prev && out_valid) begin
               total++;
               assert ({out_last, out_addr, out_data} === snap) else begin
                  bad++;
                  $error("FAIL stall_stable observed=%0h expected=%0h", {out_last, out_addr, out_data}, snap);
               end
            end
            if (r_en) begin
               total++;
               assert ((issued - xferred - ((out_valid && out_ready) ? 1 : 0)) <= 1) else begin
                  bad++;
                  $error("FAIL ren_headroom observed=%0d expected<=1",
                         issued - xferred - ((out_valid && out_ready) ? 1 : 0));
               end
               issued++;
            end
            if (out_valid && out_ready) begin
               got_addr.push_back(out_addr);
               got_data.push_back(out_data);
               got_last.push_back(out_last);
               xferred++;
            end
            if (done) done_cnt++;
            stall_prev = out_valid && !out_ready;
            snap       = {out_last, out_addr, out_data};
         end
      end
   end

   task automatic run_dump(input string tag, input logic [AW-1:0] f, input logic [AW-1:0] l,
                           input int n, input bit rnd);
      int cyc;
      int d0;
      logic [AW-1:0] ea;
      got_addr.delete();
      got_data.delete();
      got_last.delete();
      d0         = done_cnt;
      first_addr = f;
      last_addr  = l;
      out_ready  = 1'b1;
      start      = 1'b1;
      step();
      start = 1'b0;
      chk({tag, "_busy"}, busy, 1'b1);
      if (!rnd) begin
         chk({tag, "_lat_c1"}, out_valid, 1'b0);
         step();
         chk({tag, "_lat_c2"}, out_valid, 1'b0);
         step();
         chk({tag, "_lat_c3"}, out_valid, 1'b1);
         chk({tag, "_first_addr"}, out_addr, f);
      end
      cyc = 0;
      while (done !== 1'b1 && cyc < 400) begin
         if (rnd) out_ready = ($urandom_range(0, 99) < 30);
         step();
         cyc++;
      end
      out_ready = 1'b1;
      chk({tag, "_timeout"}, (cyc < 400), 1'b1);
      chk({tag, "_busy_end"}, busy, 1'b0);
      repeat (3) step();
      chk({tag, "_done_once"}, done_cnt - d0, 1);
      chk({tag, "_count"}, got_addr.size(), n);
      for (int k = 0; k < n && k < got_addr.size(); k++) begin
         ea = f + AW'(k);
         chk($sformatf("%s_addr%0d", tag, k), got_addr[k], ea);
         chk($sformatf("%s_data%0d", tag, k), got_data[k], 16'hA000 + {12'h000, ea});
         chk($sformatf("%s_last%0d", tag, k), got_last[k], (k == n - 1));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int cyc;
      reset_n    = 1'b0;
      start      = 1'b0;
      out_ready  = 1'b1;
      first_addr = 4'd0;
      last_addr  = 4'd0;
      for (int i = 0; i < DEPTH; i++) regs[i] = 16'hA000 + 16'(i);
      repeat (3) step();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_ren", r_en, 1'b0);
      chk("rst_raddr", r_addr, 4'd0);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_last", out_last, 1'b0);
      chk("rst_data", out_data, 16'h0000);
      chk("rst_oaddr", out_addr, 4'd0);

      // Release reset together with start: the first edge must accept it.
      reset_n = 1'b1;
      run_dump("full", 4'd0, 4'd15, 16, 1'b0);
      run_dump("wrap", 4'd14, 4'd1, 4, 1'b0);
      run_dump("single", 4'd7, 4'd7, 1, 1'b0);
      run_dump("bp", 4'd0, 4'd15, 16, 1'b1);

      // start while busy, then reset after the fifth word.
      got_addr.delete();
      got_data.delete();
      got_last.delete();
      d0         = done_cnt;
      first_addr = 4'd0;
      last_addr  = 4'd15;
      start      = 1'b1;
      step();
      start = 1'b0;
      step();
      first_addr = 4'd3;
      last_addr  = 4'd3;
      start      = 1'b1;
      step();
      start = 1'b0;
      cyc   = 0;
      while (got_addr.size() < 5 && cyc < 100) begin
         step();
         cyc++;
      end
      chk("int_timeout", (cyc < 100), 1'b1);
      reset_n = 1'b0;
      #1;
      chk("int_busy", busy, 1'b0);
      chk("int_ren", r_en, 1'b0);
      chk("int_valid", out_valid, 1'b0);
      chk("int_last", out_last, 1'b0);
      chk("int_raddr", r_addr, 4'd0);
      chk("int_data", out_data, 16'h0000);
      chk("int_oaddr", out_addr, 4'd0);
      repeat (3) step();
      chk("int_no_done", done_cnt - d0, 0);
      chk("int_count", got_addr.size(), 5);
      for (int k = 0; k < 5 && k < got_addr.size(); k++) begin
         chk($sformatf("int_addr%0d", k), got_addr[k], AW'(k));
         chk($sformatf("int_lastflag%0d", k), got_last[k], 1'b0);
      end
      reset_n = 1'b1;
      run_dump("after", 4'd2, 4'd5, 4, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
